// File: rtl/genius_sequencer.sv
// Genius (Simon) round controller: grows a random colour sequence, plays it on the LEDs,
// then checks the player's presses against it step by step.
module genius_sequencer #(
  parameter int unsigned MAX_LEVEL     = 16,
  parameter int unsigned SHOW_TICKS    = 25000000,
  parameter int unsigned GAP_TICKS     = 12500000,
  parameter int unsigned TIMEOUT_TICKS = 250000000
) (
  input  logic       clk,
  input  logic       R,
  input  logic       start,
  input  logic [3:0] btn,
  output logic [3:0] leds,
  output logic [3:0] level,
  output logic       busy,
  output logic       win,
  output logic       lose
);

  localparam int unsigned MaxSg    = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int unsigned MaxTicks = (MaxSg > TIMEOUT_TICKS) ? MaxSg : TIMEOUT_TICKS;
  localparam int unsigned TimerW   = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;
  localparam int unsigned IdxW     = $clog2(MAX_LEVEL);

  localparam logic [TimerW-1:0] ShowLast    = TimerW'(SHOW_TICKS - 1);
  localparam logic [TimerW-1:0] GapLast     = TimerW'(GAP_TICKS - 1);
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TIMEOUT_TICKS - 1);
  localparam logic [3:0]        LevelLast   = 4'(MAX_LEVEL - 1);

  typedef enum logic [2:0] {
    StIdle, StAdd, StShowOn, StShowOff, StWaitIn, StWin, StLose
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        level_q, level_d;
  logic [3:0]        idx_q, idx_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              busy_q, busy_d;
  logic              win_q, win_d;
  logic              lose_q, lose_d;
  logic              seq_we;
  logic [1:0]        seq_q [MAX_LEVEL];
  logic [3:0]        cur_onehot;

  assign cur_onehot = 4'b0001 << seq_q[idx_q[IdxW-1:0]];
  // Taps 16,14,13,11 in right-shifting Fibonacci form.
  assign lfsr_d     = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    seq_we  = 1'b0;
    leds    = 4'b0000;
    unique case (state_q)
      StIdle, StWin, StLose: begin
        if (state_q == StWin) leds = 4'b1111;
        if (start) begin
          state_d = StAdd;
          level_d = 4'd0;
        end
      end
      StAdd: begin
        seq_we  = 1'b1;
        idx_d   = 4'd0;
        timer_d = '0;
        state_d = StShowOn;
      end
      StShowOn: begin
        leds = cur_onehot;
        if (timer_q == ShowLast) begin
          timer_d = '0;
          state_d = StShowOff;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StShowOff: begin
        if (timer_q == GapLast) begin
          timer_d = '0;
          if (idx_q == level_q) begin
            idx_d   = 4'd0;
            state_d = StWaitIn;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = StShowOn;
          end
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StWaitIn: begin
        leds = btn;
        if (btn == 4'b0000) begin
          if (timer_q == TimeoutLast) state_d = StLose;
          else                        timer_d = timer_q + TimerW'(1);
        end else if (btn == cur_onehot) begin
          if (idx_q != level_q) begin
            idx_d   = idx_q + 4'd1;
            timer_d = '0;
          end else if (level_q == LevelLast) begin
            state_d = StWin;
          end else begin
            level_d = level_q + 4'd1;
            state_d = StAdd;
          end
        end else begin
          state_d = StLose;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_d = (state_d == StAdd) || (state_d == StShowOn) ||
                  (state_d == StShowOff) || (state_d == StWaitIn);
  assign win_d  = (state_d == StWin);
  assign lose_d = (state_d == StLose);

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q <= StIdle;
      level_q <= 4'd0;
      idx_q   <= 4'd0;
      timer_q <= '0;
      lfsr_q  <= 16'hACE1;
      busy_q  <= 1'b0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      lfsr_q  <= lfsr_d;
      busy_q  <= busy_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
    end
  end

  // Sequence memory needs no reset; entries are written before they are ever played.
  always_ff @(posedge clk) begin
    if (seq_we) seq_q[level_q[IdxW-1:0]] <= lfsr_q[1:0];
  end

  assign level = level_q;
  assign busy  = busy_q;
  assign win   = win_q;
  assign lose  = lose_q;

endmodule

// File: tb/tb_genius_sequencer.sv
// Randomised bench for genius_sequencer: a game-level model predicts every output each cycle,
// with a few literal expectations on latency, timeout, win and reset behaviour.
module tb_genius_sequencer;

  localparam int MaxLevel = 3;
  localparam int ShowT    = 2;
  localparam int GapT     = 1;
  localparam int ToT      = 20;
  localparam int Period   = ShowT + GapT;

  localparam int PhIdle = 0, PhAdd = 1, PhPlay = 2, PhWait = 3, PhWin = 4, PhLose = 5;

  logic       clk = 1'b0;
  logic       R = 1'b0;
  logic       start = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic [3:0] leds, level;
  logic       busy, win, lose;

  always #5 clk = ~clk;

  genius_sequencer #(
    .MAX_LEVEL(MaxLevel),
    .SHOW_TICKS(ShowT),
    .GAP_TICKS(GapT),
    .TIMEOUT_TICKS(ToT)
  ) dut (
    .clk(clk),
    .R(R),
    .start(start),
    .btn(btn),
    .leds(leds),
    .level(level),
    .busy(busy),
    .win(win),
    .lose(lose)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    $display("FAIL %s: cycle budget expired at %0t", name, $time);
  endtask

  // Game-level model: phase, sequence list, playback clock and idle counter.
  int          m_phase, m_level, m_play_t, m_step, m_idle;
  int          m_seq[MaxLevel];
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  function automatic logic [3:0] onehot(input int c);
    return 4'b0001 << c;
  endfunction

  task automatic model_step();
    case (m_phase)
      PhIdle, PhWin, PhLose: if (start) begin
        m_phase = PhAdd;
        m_level = 0;
      end
      PhAdd: begin
        m_seq[m_level] = int'(m_lfsr[1:0]);
        m_play_t = 0;
        m_phase  = PhPlay;
      end
      PhPlay: begin
        m_play_t++;
        if (m_play_t == (m_level + 1) * Period) begin
          m_phase = PhWait;
          m_step  = 0;
          m_idle  = 0;
        end
      end
      PhWait: begin
        if (btn == 4'b0000) begin
          if (m_idle == ToT - 1) m_phase = PhLose;
          else m_idle++;
        end else if (btn == onehot(m_seq[m_step])) begin
          if (m_step < m_level) begin
            m_step++;
            m_idle = 0;
          end else if (m_level == MaxLevel - 1) begin
            m_phase = PhWin;
          end else begin
            m_level++;
            m_phase = PhAdd;
          end
        end else begin
          m_phase = PhLose;
        end
      end
      default: m_phase = PhIdle;
    endcase
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  initial forever begin
    @(posedge clk or negedge R);
    if (!R) begin
      m_phase = PhIdle; m_level = 0; m_play_t = 0; m_step = 0; m_idle = 0;
      m_lfsr  = 16'hACE1;
    end else begin
      model_step();
    end
  end

  function automatic logic [3:0] exp_leds();
    case (m_phase)
      PhPlay:  return ((m_play_t % Period) < ShowT) ? onehot(m_seq[m_play_t / Period]) : 4'b0000;
      PhWait:  return btn;
      PhWin:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (R) begin
      chk("leds", int'(leds), int'(exp_leds()));
      chk("level", int'(level), m_level);
      chk("busy", int'(busy), int'(m_phase inside {PhAdd, PhPlay, PhWait}));
      chk("win", int'(win), int'(m_phase == PhWin));
      chk("lose", int'(lose), int'(m_phase == PhLose));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic press(input logic [3:0] b);
    btn = b;
    tick();
    btn = 4'b0000;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_phase(input int ph, input string name);
    int n = 0;
    while (m_phase != ph && n < 200) begin
      btn = (m_phase == PhPlay) ? 4'($urandom) : 4'b0000;
      tick();
      n++;
    end
    btn = 4'b0000;
    if (m_phase != ph) bound_fail(name);
  endtask

  task automatic play_round(input int gapmax);
    int lvl = m_level;
    for (int s = 0; s <= lvl; s++) begin
      int gap = $urandom_range(0, gapmax);
      for (int i = 0; i < gap; i++) tick();
      press(onehot(m_seq[m_step]));
    end
  endtask

  task automatic random_game();
    int budget = 2000;
    pulse_start();
    while (m_phase inside {PhAdd, PhPlay, PhWait} && budget > 0) begin
      if (m_phase == PhWait) begin
        int gap;
        logic [3:0] b;
        gap = ($urandom_range(0, 15) == 0) ? 22 : $urandom_range(0, 3);
        for (int i = 0; i < gap && m_phase == PhWait; i++) begin
          tick();
          budget--;
        end
        if (m_phase == PhWait) begin
          if ($urandom_range(0, 9) != 0) b = onehot(m_seq[m_step]);
          else b = 4'($urandom_range(1, 15));
          press(b);
          budget--;
        end
      end else begin
        btn   = 4'($urandom);
        start = ($urandom_range(0, 7) == 0);
        tick();
        start = 1'b0;
        btn   = 4'b0000;
        budget--;
      end
    end
    if (budget <= 0) bound_fail("random_game");
  endtask

  initial begin
    logic [3:0] bad;
    repeat (3) tick();
    chk("rst_leds", int'(leds), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_win", int'(win), 0);
    chk("rst_lose", int'(lose), 0);
    R = 1'b1;
    repeat (4) tick();
    chk("idle_busy", int'(busy), 0);

    // First game: latency and playback shape, then a full win.
    pulse_start();
    chk("busy_after_start", int'(busy), 1);
    tick();
    chk("led1_onehot", $countones(leds), 1);
    tick();
    chk("led2_onehot", $countones(leds), 1);
    tick();
    chk("gap_dark", int'(leds), 0);
    tick();
    chk("wait_level0", int'(level), 0);
    chk("wait_busy", int'(busy), 1);
    for (int r = 0; r < MaxLevel; r++) begin
      wait_phase(PhWait, "reach_wait");
      chk("round_level", int'(level), r);
      play_round(2);
    end
    chk("win_flag", int'(win), 1);
    chk("win_leds", int'(leds), 15);
    chk("win_busy", int'(busy), 0);
    chk("win_level", int'(level), MaxLevel - 1);

    // Wrong colour on step 1 of round 1.
    pulse_start();
    wait_phase(PhWait, "g2_r0");
    play_round(0);
    wait_phase(PhWait, "g2_r1");
    press(onehot(m_seq[0]));
    bad = onehot((m_seq[1] + 1) % 4);
    press(bad);
    chk("wrong_lose", int'(lose), 1);
    chk("wrong_level", int'(level), 1);
    chk("wrong_leds", int'(leds), 0);

    // Multi-bit press loses.
    pulse_start();
    chk("restart_level", int'(level), 0);
    chk("restart_lose", int'(lose), 0);
    wait_phase(PhWait, "g3_r0");
    press(4'b0011);
    chk("multi_lose", int'(lose), 1);

    // Timeout after 20 idle cycles.
    pulse_start();
    wait_phase(PhWait, "g4_r0");
    repeat (ToT - 1) tick();
    chk("pre_timeout", int'(lose), 0);
    tick();
    chk("timeout_lose", int'(lose), 1);

    // A press on the last allowed cycle keeps play going.
    pulse_start();
    wait_phase(PhWait, "g5_r0");
    repeat (ToT - 1) tick();
    press(onehot(m_seq[0]));
    chk("late_press_lose", int'(lose), 0);
    chk("late_press_level", int'(level), 1);
    wait_phase(PhWait, "g5_r1");
    repeat (ToT - 1) tick();
    press(onehot(m_seq[0]));
    chk("late_step_lose", int'(lose), 0);
    repeat (ToT - 1) tick();
    press(onehot(m_seq[1]));
    chk("late_round_level", int'(level), 2);

    // Asynchronous reset in the middle of playback.
    wait_phase(PhPlay, "g5_play");
    tick();
    #1 R = 1'b0;
    #1;
    chk("arst_leds", int'(leds), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_level", int'(level), 0);
    chk("arst_win", int'(win), 0);
    chk("arst_lose", int'(lose), 0);
    repeat (2) tick();
    R = 1'b1;
    repeat (5) tick();
    chk("post_rst_idle", int'(busy), 0);

    repeat (8) random_game();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
